filter_border_align: RTL and testbench
======================================

Name: filter_border_align

Overview:
- Sits directly downstream of the NxN convolution filter.
- The filter shifts every clock and carries no valid/position information. This block re-attaches frame timing to the filter output:
  - delays the input-side valid/sop by the filter latency;
  - generates x/y counters aligned to the window centre;
  - forces border pixels (incomplete window) to a fixed value;
  - saturates the wide accumulator result to pixel width.
- Output is a valid/sop/eol pixel stream for the colour-detection stage.

Parameters:
- N, 3, filter window size (odd).
- LINE_WIDTH, 640, pixels per line.
- FRAME_HEIGHT, 480, lines per frame.
- PRECISION, 31, width of filter result.
- PIXEL_W, 8, output pixel width.
- LATENCY, (N/2)*LINE_WIDTH + N/2 + 2, cycles from a pixel entering the filter to its centred result leaving the filter.
- BORDER_VALUE, 0, value driven on border pixels.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  pixel valid, tapped at the filter's data_in
- in_sop  in  1  first pixel of frame, tapped at the filter's data_in
- data_in  in  PRECISION  filter data_out
- out_valid  out  1  output pixel valid
- out_sop  out  1  first output pixel of frame
- out_eol  out  1  last pixel of each line
- out_x  out  $clog2(LINE_WIDTH)  column of output pixel
- out_y  out  $clog2(FRAME_HEIGHT)  row of output pixel
- data_out  out  PIXEL_W  aligned, masked, saturated pixel
- err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (rst==0 at posedge clk):
  - delay line cleared;
  - state WAIT_SOP;
  - out_valid, out_sop, out_eol, out_x, out_y, data_out, err all 0.
- Delay line:
  - {in_valid, in_sop} shifted every clock through LATENCY stages.
  - d_valid/d_sop are the tap outputs, coincident with the matching data_in.
- State machine:
  - WAIT_SOP: d_valid without d_sop is ignored (no output). d_valid && d_sop -> ACTIVE, x=0, y=0, pixel emitted.
  - ACTIVE, each d_valid: x increments. At x==LINE_WIDTH-1: x wraps to 0, y increments. At x==LINE_WIDTH-1 && y==FRAME_HEIGHT-1: -> WAIT_SOP.
  - ACTIVE, d_valid==0: framing gap, because the filter cannot stall. err pulses 1 cycle, state -> WAIT_SOP, no output that cycle.
  - ACTIVE, d_sop mid-frame: err pulses; counters restart at 0,0; pixel emitted as new sop; stays ACTIVE.
- Output register, 1 cycle after the d_valid cycle:
  - out_valid = emitted.
  - out_sop = (x==0 && y==0).
  - out_eol = (x==LINE_WIDTH-1).
  - out_x/out_y = counters before increment.
- Border: x < N/2, x >= LINE_WIDTH-N/2, y < N/2 or y >= FRAME_HEIGHT-N/2 -> data_out = BORDER_VALUE.
- Saturation otherwise: data_in treated unsigned; data_in > 2^PIXEL_W-1 -> all ones; else low PIXEL_W bits.
- When out_valid==0, data_out and out_x/out_y hold their last values; sop/eol are 0.
- Total latency: LATENCY+1 cycles from in_valid to out_valid.
- Reset mid-frame: everything cleared. Pixels already in the filter are dropped because the delay line is empty.

Optional Feature:
- Macro FILTER_BORDER_THRESHOLD_EN.
- Defined:
  - adds input port thresh [PIXEL_W-1:0];
  - post-saturation non-border pixel = (sat >= thresh) ? all ones : 0;
  - border pixels still BORDER_VALUE;
  - latency unchanged (compare in the same output register stage).
- Undefined: port absent, saturated value passed through.

Decomposition:
- Shared package vision_pkg:
  - default LINE_WIDTH and FRAME_HEIGHT constants;
  - PIXEL_W;
  - state enum {WAIT_SOP, ACTIVE};
  - saturate function.
- One sub-module: valid_delay_line (WIDTH=2, DEPTH=LATENCY, synchronous active-low clear), reusable by other filter stages.

Test Plan (N=3, LINE_WIDTH=8, FRAME_HEIGHT=6, LATENCY=11):
- Continuous frame of 48 pixels with in_sop on the first -> first out_valid 12 cycles after the first in_valid, with out_sop=1 at x=0,y=0. 48 valid outputs. out_eol at x=7 on each of 6 lines. State returns to WAIT_SOP.
- Same frame with data_in=100 constant -> rows 0/5 and columns 0/7 give data_out=0; interior gives 100.
- data_in=300, then data_in=255 -> data_out=255 for both (saturation).
- in_valid dropped for 1 cycle at pixel 20 -> err pulses exactly once, LATENCY+1 cycles later. No further outputs until the next in_sop.
- in_sop reasserted at pixel 30 -> err pulse; the next output has out_sop=1, x=0, y=0.
- rst low for 1 cycle mid-frame -> all outputs 0 next cycle. No out_valid until a new in_sop has propagated. With FILTER_BORDER_THRESHOLD_EN and thresh=128: interior 127->0, 128->255.

Source files
------------

// File: rtl/vision_pkg.sv
// Shared constants, frame state encoding and saturation helper for the vision
// pipeline stages that sit behind the convolution filter.
package vision_pkg;

  localparam int DEFAULT_LINE_WIDTH   = 640;
  localparam int DEFAULT_FRAME_HEIGHT = 480;
  localparam int PIXEL_W              = 8;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    ACTIVE   = 1'b1
  } frameState_t;

  // Clamp an unsigned value to the largest code representable in 'width' bits.
  function automatic logic [63:0] saturate(input logic [63:0] value, input int unsigned width);
    logic [63:0] maxCode;
    maxCode = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value > maxCode) ? maxCode : value;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for sideband flags (valid/sop) that must track a
// pipeline which cannot stall; synchronous active-low clear empties every stage.
module valid_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stages_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst) begin
          stages_q <= '0;
        end else begin
          stages_q <= data_i;
        end
      end
    end else begin : g_chain
      // Newest entry enters at index 0, oldest leaves from the top index.
      always_ff @(posedge clk) begin
        if (!rst) begin
          stages_q <= '0;
        end else begin
          stages_q <= {stages_q[DEPTH-2:0], data_i};
        end
      end
    end
  endgenerate

  assign data_o = stages_q[DEPTH-1];

endmodule

// File: rtl/filter_border_align.sv
// Re-attaches frame timing to the NxN filter output: delayed valid/sop, centred
// x/y counters, border masking and saturation. Option: FILTER_BORDER_THRESHOLD_EN.
module filter_border_align
  import vision_pkg::*;
#(
  parameter int N            = 3,
  parameter int LINE_WIDTH   = DEFAULT_LINE_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int PRECISION    = 31,
  parameter int PIXEL_W      = vision_pkg::PIXEL_W,
  parameter int LATENCY      = (N/2)*LINE_WIDTH + N/2 + 2,
  parameter int BORDER_VALUE = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_sop,
  input  logic [PRECISION-1:0]            data_in,
`ifdef FILTER_BORDER_THRESHOLD_EN
  input  logic [PIXEL_W-1:0]              thresh,
`endif
  output logic                            out_valid,
  output logic                            out_sop,
  output logic                            out_eol,
  output logic [$clog2(LINE_WIDTH)-1:0]   out_x,
  output logic [$clog2(FRAME_HEIGHT)-1:0] out_y,
  output logic [PIXEL_W-1:0]              data_out,
  output logic                            err
);

  localparam int X_W  = $clog2(LINE_WIDTH);
  localparam int Y_W  = $clog2(FRAME_HEIGHT);
  localparam int HALF = N / 2;
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_HEIGHT - 1);

  logic [1:0]         delayedFlags;
  logic               dValid;
  logic               dSop;

  frameState_t        state_q, state_d;
  logic [X_W-1:0]     xCount_q, xCount_d;
  logic [Y_W-1:0]     yCount_q, yCount_d;

  logic               emit;
  logic               frameErr;
  logic [X_W-1:0]     pixX;
  logic [Y_W-1:0]     pixY;
  logic               isBorder;
  logic [PIXEL_W-1:0] satPix;
  logic [PIXEL_W-1:0] pixelValue;

  logic               outValid_q;
  logic               outSop_q;
  logic               outEol_q;
  logic [X_W-1:0]     outX_q;
  logic [Y_W-1:0]     outY_q;
  logic [PIXEL_W-1:0] dataOut_q;
  logic               err_q;

  // The filter never stalls, so its input-side flags only need a fixed delay.
  valid_delay_line #(
    .WIDTH (2),
    .DEPTH (LATENCY)
  ) u_valid_delay (
    .clk    (clk),
    .rst    (rst),
    .data_i ({in_valid, in_sop}),
    .data_o (delayedFlags)
  );

  assign dValid = delayedFlags[1];
  assign dSop   = delayedFlags[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= WAIT_SOP;
      xCount_q <= '0;
      yCount_q <= '0;
    end else begin
      state_q  <= state_d;
      xCount_q <= xCount_d;
      yCount_q <= yCount_d;
    end
  end

  // pixX/pixY are the coordinates of the pixel emitted this cycle; a sop
  // always forces them to the frame origin, even mid-frame.
  always_comb begin
    state_d  = state_q;
    xCount_d = xCount_q;
    yCount_d = yCount_q;
    emit     = 1'b0;
    frameErr = 1'b0;
    pixX     = xCount_q;
    pixY     = yCount_q;

    case (state_q)
      WAIT_SOP: begin
        if (dValid && dSop) begin
          emit = 1'b1;
          pixX = '0;
          pixY = '0;
        end
      end
      ACTIVE: begin
        if (!dValid) begin
          frameErr = 1'b1;
          state_d  = WAIT_SOP;
        end else begin
          emit = 1'b1;
          if (dSop) begin
            frameErr = 1'b1;
            pixX     = '0;
            pixY     = '0;
          end
        end
      end
      default: state_d = WAIT_SOP;
    endcase

    if (emit) begin
      state_d = ACTIVE;
      if (pixX == X_LAST) begin
        xCount_d = '0;
        if (pixY == Y_LAST) begin
          yCount_d = '0;
          state_d  = WAIT_SOP;
        end else begin
          yCount_d = pixY + 1'b1;
        end
      end else begin
        xCount_d = pixX + 1'b1;
        yCount_d = pixY;
      end
    end
  end

  assign isBorder = (32'(pixX) <  HALF) || (32'(pixX) >= LINE_WIDTH - HALF) ||
                    (32'(pixY) <  HALF) || (32'(pixY) >= FRAME_HEIGHT - HALF);

  assign satPix = PIXEL_W'(saturate(64'(data_in), PIXEL_W));

`ifdef FILTER_BORDER_THRESHOLD_EN
  assign pixelValue = isBorder ? PIXEL_W'(BORDER_VALUE) : ((satPix >= thresh) ? '1 : '0);
`else
  assign pixelValue = isBorder ? PIXEL_W'(BORDER_VALUE) : satPix;
`endif

  // Coordinates and data hold between pixels; sop/eol are qualified by emit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outValid_q <= 1'b0;
      outSop_q   <= 1'b0;
      outEol_q   <= 1'b0;
      outX_q     <= '0;
      outY_q     <= '0;
      dataOut_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      outValid_q <= emit;
      outSop_q   <= emit && (pixX == '0) && (pixY == '0);
      outEol_q   <= emit && (pixX == X_LAST);
      err_q      <= frameErr;
      if (emit) begin
        outX_q    <= pixX;
        outY_q    <= pixY;
        dataOut_q <= pixelValue;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_sop   = outSop_q;
  assign out_eol   = outEol_q;
  assign out_x     = outX_q;
  assign out_y     = outY_q;
  assign data_out  = dataOut_q;
  assign err       = err_q;

endmodule

// File: tb/tb_filter_border_align.sv
// Self-checking bench for filter_border_align on a small 8x6 frame; a pixel-index
// reference model predicts every output cycle. Threshold option: FILTER_BORDER_THRESHOLD_EN.
module tb_filter_border_align;

  localparam int N         = 3;
  localparam int LW        = 8;
  localparam int FH        = 6;
  localparam int PRECISION = 31;
  localparam int PIXEL_W   = 8;
  localparam int LATENCY   = 11;
  localparam int BORDER    = 0;
  localparam int HALF      = N / 2;
  localparam int MAXPIX    = (1 << PIXEL_W) - 1;
  localparam int XW        = $clog2(LW);
  localparam int YW        = $clog2(FH);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_sop = 1'b0;
  logic [PRECISION-1:0] data_in = '0;
  logic                 out_valid;
  logic                 out_sop;
  logic                 out_eol;
  logic [XW-1:0]        out_x;
  logic [YW-1:0]        out_y;
  logic [PIXEL_W-1:0]   data_out;
  logic                 err;
`ifdef FILTER_BORDER_THRESHOLD_EN
  logic [PIXEL_W-1:0]   thresh = 8'd128;
`endif

  always #5 clk = ~clk;

  filter_border_align #(
    .N            (N),
    .LINE_WIDTH   (LW),
    .FRAME_HEIGHT (FH),
    .PRECISION    (PRECISION),
    .PIXEL_W      (PIXEL_W),
    .LATENCY      (LATENCY),
    .BORDER_VALUE (BORDER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .data_in   (data_in),
`ifdef FILTER_BORDER_THRESHOLD_EN
    .thresh    (thresh),
`endif
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eol   (out_eol),
    .out_x     (out_x),
    .out_y     (out_y),
    .data_out  (data_out),
    .err       (err)
  );

  // Reference model: flags travel through a queue, the frame is tracked as a
  // linear pixel index and x/y are derived from it by division.
  logic [1:0] delayQ[$];
  bit         inFrame;
  int         pixIdx;
  bit         eValid, eSop, eEol, eErr;
  int         eX, eY, eData;

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int validSeen, errSeen, firstIn, firstOut;

  task automatic modelReset();
    delayQ = {};
    for (int i = 0; i < LATENCY; i++) delayQ.push_back(2'b00);
    inFrame = 0;
    pixIdx  = 0;
    eValid = 0; eSop = 0; eEol = 0; eErr = 0;
    eX = 0; eY = 0; eData = 0;
  endtask

  task automatic modelStep(input bit r, input bit v, input bit s, input logic [31:0] d);
    logic [1:0] tap;
    bit         emit, border;
    int         idx, x, y;
    longint     sat;
    if (!r) begin
      modelReset();
      return;
    end
    tap = delayQ.pop_front();
    delayQ.push_back({v, s});
    emit = 0; idx = 0; eErr = 0;
    if (!inFrame) begin
      if (tap == 2'b11) emit = 1;
    end else if (!tap[1]) begin
      eErr = 1;
      inFrame = 0;
    end else if (tap[0]) begin
      eErr = 1;
      emit = 1;
    end else begin
      emit = 1;
      idx = pixIdx;
    end
    eValid = emit;
    eSop = 0;
    eEol = 0;
    if (emit) begin
      pixIdx  = idx + 1;
      inFrame = (pixIdx < LW * FH);
      x = idx % LW;
      y = idx / LW;
      border = (x < HALF) || (x >= LW - HALF) || (y < HALF) || (y >= FH - HALF);
      sat = (longint'(d) > MAXPIX) ? MAXPIX : longint'(d);
      eSop = (idx == 0);
      eEol = (x == LW - 1);
      eX = x;
      eY = y;
`ifdef FILTER_BORDER_THRESHOLD_EN
      eData = border ? BORDER : ((sat >= longint'(thresh)) ? MAXPIX : 0);
`else
      eData = border ? BORDER : int'(sat);
`endif
    end
  endtask

  task automatic compareField(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cycleCount, actual, expected);
    end
  endtask

  task automatic checkOutput();
    compareField("out_valid", out_valid, eValid);
    compareField("out_sop", out_sop, eSop);
    compareField("out_eol", out_eol, eEol);
    compareField("err", err, eErr);
    compareField("out_x", out_x, eX);
    compareField("out_y", out_y, eY);
    compareField("data_out", data_out, eData);
    if (out_valid === 1'b1) begin
      validSeen++;
      if (firstOut < 0) firstOut = cycleCount;
    end
    if (err === 1'b1) errSeen++;
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit s, input logic [31:0] d);
    rst      = r;
    in_valid = v;
    in_sop   = s;
    data_in  = d[PRECISION-1:0];
    if (r && v && firstIn < 0) firstIn = cycleCount;
    modelStep(r, v, s, {1'b0, d[PRECISION-1:0]});
    @(posedge clk);
    cycleCount++;
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [31:0] pickData(input int mode, input int pix);
    case (mode)
      0:       return $urandom & 32'h7fff_ffff;
      1:       return 32'd100;
      2:       return 32'($urandom_range(0, 511));
      default: return (pix % 2 == 0) ? 32'd127 : 32'd128;
    endcase
  endfunction

  typedef struct {
    int dataMode;
    int dropAt;
    int sopAt;
    int resetAt;
    int expValid;
    int expErr;
  } scenario_t;

`ifdef FILTER_BORDER_THRESHOLD_EN
  localparam int NSCEN = 8;
`else
  localparam int NSCEN = 7;
`endif

  scenario_t scen[NSCEN];

  initial begin
    scen[0] = '{0, -1, -1, -1, 48, 0};
    scen[1] = '{1, -1, -1, -1, 48, 0};
    scen[2] = '{2, -1, -1, -1, 48, 0};
    scen[3] = '{0, 20, -1, -1, 20, 1};
    scen[4] = '{2, -1, 30, -1, 48, 2};
    scen[5] = '{1, -1, -1, 25, 14, 0};
    scen[6] = '{0, -1, -1, -1, 48, 0};
`ifdef FILTER_BORDER_THRESHOLD_EN
    scen[7] = '{3, -1, -1, -1, 48, 0};
`endif

    modelReset();
    validSeen = 0; errSeen = 0; firstIn = -1; firstOut = -1;
    repeat (3) applyStimulus(0, 0, 0, $urandom);

    for (int s = 0; s < NSCEN; s++) begin
      int  pix;
      bit  dropped;
      validSeen = 0; errSeen = 0; firstIn = -1; firstOut = -1;
      pix = 0;
      dropped = 0;
      while (pix < LW * FH) begin
        if (pix == scen[s].dropAt && !dropped) begin
          dropped = 1;
          applyStimulus(1, 0, 0, pickData(scen[s].dataMode, pix));
        end else begin
          applyStimulus(pix != scen[s].resetAt, 1, (pix == 0) || (pix == scen[s].sopAt),
                        pickData(scen[s].dataMode, pix));
          pix++;
        end
      end
      repeat (LATENCY + 4) applyStimulus(1, 0, 0, $urandom);
      compareField($sformatf("scen%0d_validCount", s), validSeen, scen[s].expValid);
      compareField($sformatf("scen%0d_errCount", s), errSeen, scen[s].expErr);
      if (s == 0) compareField("firstLatency", firstOut - firstIn, LATENCY + 1);
    end

    // A valid pixel without sop while idle must be ignored silently.
    validSeen = 0; errSeen = 0;
    applyStimulus(1, 1, 0, 32'd55);
    repeat (LATENCY + 4) applyStimulus(1, 0, 0, $urandom);
    compareField("straySop_validCount", validSeen, 0);
    compareField("straySop_errCount", errSeen, 0);

    // Reset held while a frame is mid-flight, then a fresh frame recovers.
    validSeen = 0; errSeen = 0;
    for (int p = 0; p < 16; p++) applyStimulus(1, 1, p == 0, 32'd100);
    applyStimulus(0, 1, 0, 32'd100);
    compareField("resetClears_valid", out_valid, 0);
    compareField("resetClears_data", data_out, 0);
    for (int p = 0; p < LW * FH; p++) applyStimulus(1, 1, p == 0, 32'($urandom_range(0, 400)));
    repeat (LATENCY + 4) applyStimulus(1, 0, 0, $urandom);
    compareField("recover_validCount", validSeen, 5 + LW * FH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
